// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with DEPTH-entry FIFOs between processor and mesh router.
// Define CARDINAL_NIC_OVF_FLAG_EN for a sticky dropped-write flag in status bit 0.
module cardinal_nic_fifo #(
  parameter int PAC_WIDTH = 64,
  parameter int DEPTH     = 4,
  localparam int CNT_W    = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:1]           addr,
  input  logic [0:PAC_WIDTH-1] d_in,
  output logic [0:PAC_WIDTH-1] d_out,
  input  logic                 nicEn,
  input  logic                 nicWrEn,
  input  logic                 net_si,
  output logic                 net_ri,
  input  logic [0:PAC_WIDTH-1] net_di,
  output logic                 net_so,
  input  logic                 net_ro,
  output logic [0:PAC_WIDTH-1] net_do,
  input  logic                 net_polarity
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CB    = PAC_WIDTH-1-CNT_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [0:PAC_WIDTH-1] in_mem  [DEPTH];
  logic [0:PAC_WIDTH-1] out_mem [DEPTH];
  logic [PTR_W-1:0]     in_wp, in_rp, out_wp, out_rp;
  logic [CNT_W-1:0]     in_cnt, out_cnt;

  logic rd, wr;
  logic a_in, a_ist, a_out, a_ost;
  logic in_push, in_pop, out_push, out_pop;
  logic out_full, ovf_bit;
  logic [0:PAC_WIDTH-1] in_stat, out_stat;

  assign rd    = nicEn & ~nicWrEn;
  assign wr    = nicEn & nicWrEn;
  assign a_in  = (addr == 2'b00);
  assign a_ist = (addr == 2'b01);
  assign a_out = (addr == 2'b10);
  assign a_ost = (addr == 2'b11);

  assign net_ri   = (in_cnt != FULL);
  assign out_full = (out_cnt == FULL);

  assign in_push  = net_si & net_ri;
  assign in_pop   = rd & a_in & (in_cnt != '0);
  assign out_push = wr & a_out & ~out_full;
  // Only the packet whose VC matches this cycle's phase may leave.
  assign out_pop  = (out_cnt != '0) & net_ro
                  & (out_mem[out_rp][0] == net_polarity);

`ifdef CARDINAL_NIC_OVF_FLAG_EN
  logic ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf <= 1'b0;
    else if (wr && a_out && out_full)
      ovf <= 1'b1;
    else if (rd && a_ost)
      ovf <= 1'b0;
  end

  assign ovf_bit = ovf;
`else
  assign ovf_bit = 1'b0;
`endif

  always_comb begin
    in_stat                 = '0;
    in_stat[PAC_WIDTH-1]    = (in_cnt != '0);
    in_stat[CB +: CNT_W]    = in_cnt;
    in_stat[0]              = ovf_bit;
    out_stat                = '0;
    out_stat[PAC_WIDTH-1]   = out_full;
    out_stat[CB +: CNT_W]   = out_cnt;
    out_stat[0]             = ovf_bit;
  end

  always_ff @(posedge clk) begin
    if (in_push)
      in_mem[in_wp] <= net_di;
    if (out_push)
      out_mem[out_wp] <= d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wp   <= '0;
      in_rp   <= '0;
      in_cnt  <= '0;
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push)
        in_wp <= in_wp + 1'b1;
      if (in_pop)
        in_rp <= in_rp + 1'b1;
      if (out_push)
        out_wp <= out_wp + 1'b1;
      if (out_pop)
        out_rp <= out_rp + 1'b1;
      in_cnt  <= in_cnt + CNT_W'(in_push) - CNT_W'(in_pop);
      out_cnt <= out_cnt + CNT_W'(out_push) - CNT_W'(out_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd) begin
      unique case (1'b1)
        a_in:    d_out <= in_pop ? in_mem[in_rp] : '0;
        a_ist:   d_out <= in_stat;
        a_ost:   d_out <= out_stat;
        default: d_out <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      net_so <= out_pop;
      if (out_pop)
        net_do <= out_mem[out_rp];
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed bench for cardinal_nic_fifo: reset, send, blocking,
// store path, input full and simultaneous push/pop.
module tb_cardinal_nic_fifo;

  logic        clk;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int total = 0;
  int bad   = 0;

`ifdef CARDINAL_NIC_OVF_FLAG_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  cardinal_nic_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status word: flag at bit 63, count in bits 60..62, overflow at bit 0.
  function automatic logic [0:63] stat(input logic f, input int c,
                                       input logic o);
    logic [0:63] s;
    s        = '0;
    s[63]    = f;
    s[60:62] = c[2:0];
    s[0]     = o;
    return s;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    net_ro = 0; net_polarity = 0;
    nicEn = 1; nicWrEn = 1; addr = 2'b10;
    d_in = 64'h11; step;
    d_in = 64'h22; step;
    d_in = 64'h33; step;
    nicWrEn = 0; addr = 2'b11; step;
    total++;
    if (d_out !== stat(0, 3, 0)) begin
      bad++; $display("FAIL rst_pre_stat got=%h exp=%h", d_out, stat(0, 3, 0));
    end
    nicEn = 0; net_ro = 1; step; net_ro = 0;
    total++;
    if (net_so !== 1'b1 || net_do !== 64'h11) begin
      bad++; $display("FAIL rst_pre_send got=%b/%h exp=1/%h", net_so, net_do, 64'h11);
    end
    #2 reset = 1;
    #1;
    total++;
    if (net_so !== 1'b0 || net_do !== '0 || d_out !== '0) begin
      bad++;
      $display("FAIL rst_async got so=%b do=%h dout=%h exp 0/0/0", net_so, net_do, d_out);
    end
    @(posedge clk); #1 reset = 0;
    nicEn = 1; nicWrEn = 0; addr = 2'b11; step; nicEn = 0;
    total++;
    if (d_out !== stat(0, 0, 0)) begin
      bad++; $display("FAIL rst_out_stat got=%h exp=%h", d_out, stat(0, 0, 0));
    end
    total++;
    if (net_ri !== 1'b1) begin
      bad++; $display("FAIL rst_ri got=%b exp=1", net_ri);
    end
  endtask

  task automatic test_send;
    logic [0:63] p [3];
    logic [7:0]  so_exp;
    logic [0:63] do_exp;
    p = '{64'h8000_0000_0000_0A01, 64'h8000_0000_0000_0B02,
          64'h8000_0000_0000_0C03};
    so_exp = 8'b0010_1010;
    net_ro = 1;
    for (int k = 0; k < 8; k++) begin
      net_polarity = k[0];
      if (k < 3) begin
        nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = p[k];
      end else begin
        nicEn = 0;
      end
      step;
      if (k < 1)      do_exp = '0;
      else if (k < 3) do_exp = p[0];
      else if (k < 5) do_exp = p[1];
      else            do_exp = p[2];
      total++;
      if (net_so !== so_exp[k] || net_do !== do_exp) begin
        bad++;
        $display("FAIL send_c%0d got=%b/%h exp=%b/%h", k, net_so, net_do, so_exp[k], do_exp);
      end
    end
    net_ro = 0;
  endtask

  task automatic test_block;
    logic [0:63] q [5];
    q = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
    net_ro = 0; net_polarity = 0;
    nicEn = 1; nicWrEn = 1; addr = 2'b10;
    for (int k = 0; k < 5; k++) begin
      d_in = q[k]; step;
    end
    nicWrEn = 0; addr = 2'b11; step;
    total++;
    if (d_out !== stat(1, 4, OVF)) begin
      bad++; $display("FAIL blk_full got=%h exp=%h", d_out, stat(1, 4, OVF));
    end
    step;
    total++;
    if (d_out !== stat(1, 4, 0)) begin
      bad++; $display("FAIL blk_clr got=%h exp=%h", d_out, stat(1, 4, 0));
    end
    nicWrEn = 1; addr = 2'b10; d_in = 64'h66; net_ro = 1;
    for (int k = 0; k < 5; k++) begin
      step;
      nicEn = 0;
      total++;
      if (net_so !== (k < 4) || net_do !== q[(k < 4) ? k : 3]) begin
        bad++;
        $display("FAIL blk_drain%0d got=%b/%h exp=%b/%h", k, net_so, net_do,
                 (k < 4), q[(k < 4) ? k : 3]);
      end
    end
    nicEn = 1; nicWrEn = 0; addr = 2'b11; step; nicEn = 0;
    total++;
    if (d_out !== stat(0, 0, OVF)) begin
      bad++; $display("FAIL blk_empty got=%h exp=%h", d_out, stat(0, 0, OVF));
    end
    net_ro = 0;
  endtask

  task automatic test_store;
    logic [0:63] v [3];
    v = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
          64'h1234_5678_9ABC_DEF0};
    net_si = 1;
    for (int k = 0; k < 3; k++) begin
      net_di = v[k]; step;
    end
    net_si = 0;
    nicEn = 1; nicWrEn = 0; addr = 2'b01; step;
    total++;
    if (d_out !== stat(1, 3, 0)) begin
      bad++; $display("FAIL st_stat got=%h exp=%h", d_out, stat(1, 3, 0));
    end
    addr = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step;
      total++;
      if (d_out !== ((k < 3) ? v[(k < 3) ? k : 0] : 64'h0)) begin
        bad++;
        $display("FAIL st_rd%0d got=%h exp=%h", k, d_out,
                 ((k < 3) ? v[(k < 3) ? k : 0] : 64'h0));
      end
    end
    nicEn = 0;
  endtask

  task automatic test_in_full;
    logic [0:63] f [5];
    f = '{64'hF1, 64'hF2, 64'hF3, 64'hF4, 64'hF5};
    net_si = 1;
    for (int k = 0; k < 4; k++) begin
      net_di = f[k]; step;
    end
    net_si = 0;
    total++;
    if (net_ri !== 1'b0) begin
      bad++; $display("FAIL inf_ri0 got=%b exp=0", net_ri);
    end
    nicEn = 1; nicWrEn = 0; addr = 2'b01; step;
    total++;
    if (d_out !== stat(1, 4, 0)) begin
      bad++; $display("FAIL inf_stat got=%h exp=%h", d_out, stat(1, 4, 0));
    end
    addr = 2'b00; step;
    total++;
    if (d_out !== f[0] || net_ri !== 1'b1) begin
      bad++; $display("FAIL inf_pop got=%h/%b exp=%h/1", d_out, net_ri, f[0]);
    end
    net_si = 1; net_di = f[4]; step; net_si = 0;
    total++;
    if (d_out !== f[1]) begin
      bad++; $display("FAIL inf_pushpop got=%h exp=%h", d_out, f[1]);
    end
    addr = 2'b01; step;
    total++;
    if (d_out !== stat(1, 3, 0)) begin
      bad++; $display("FAIL inf_cnt got=%h exp=%h", d_out, stat(1, 3, 0));
    end
    addr = 2'b00;
    for (int k = 2; k < 5; k++) begin
      step;
      total++;
      if (d_out !== f[k]) begin
        bad++; $display("FAIL inf_rd%0d got=%h exp=%h", k, d_out, f[k]);
      end
    end
    nicEn = 0;
  endtask

  task automatic test_simul;
    logic [0:63] r [3];
    r = '{64'h0101, 64'h0202, 64'h0303};
    net_ro = 0; net_polarity = 0;
    nicEn = 1; nicWrEn = 1; addr = 2'b10;
    d_in = r[0]; step;
    d_in = r[1]; step;
    d_in = r[2]; net_ro = 1; step;
    total++;
    if (net_so !== 1'b1 || net_do !== r[0]) begin
      bad++; $display("FAIL sim_send got=%b/%h exp=1/%h", net_so, net_do, r[0]);
    end
    nicWrEn = 0; addr = 2'b11; net_ro = 0; step;
    total++;
    if (d_out !== stat(0, 2, 0)) begin
      bad++; $display("FAIL sim_cnt got=%h exp=%h", d_out, stat(0, 2, 0));
    end
    nicEn = 0; net_ro = 1;
    for (int k = 1; k < 4; k++) begin
      step;
      total++;
      if (net_so !== (k < 3) || net_do !== r[(k < 3) ? k : 2]) begin
        bad++;
        $display("FAIL sim_ord%0d got=%b/%h exp=%b/%h", k, net_so, net_do,
                 (k < 3), r[(k < 3) ? k : 2]);
      end
    end
    net_ro = 0;
  endtask

  initial begin
    reset = 1; addr = 2'b00; d_in = '0; nicEn = 0; nicWrEn = 0;
    net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset;
    test_send;
    test_block;
    test_store;
    test_in_full;
    test_simul;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
